ccg_resp_compactor: RTL and testbench



---
 rtl/ccg_resp_compactor.sv | 137 +++++++++++++
 tb/tb_ccg_resp_compactor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ccg_resp_compactor.sv
// Pattern sweeper and MISR response compactor for a combinational benchmark.
// Drives every N_IN-bit pattern, folds each handshaked response into a signature and grades it.
module ccg_resp_compactor #(
   parameter int                N_IN    = 9,
   parameter int                N_OUT   = 12,
   parameter int                SIG_W   = 16,
   parameter logic [SIG_W-1:0]  POLY    = 16'hB400,
   parameter logic [SIG_W-1:0]  SEED    = 16'h0001,
   parameter logic [SIG_W-1:0]  GOLDEN  = 16'h0000,
   parameter int                TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   pat,
   output logic              pat_valid,
   input  logic [N_OUT-1:0]  resp,
   input  logic              resp_valid,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              err,
   output logic [SIG_W-1:0]  signature
);

   localparam int                WAIT_W    = $clog2(TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [N_IN-1:0]   PAT_LAST  = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_FIN   = 2'd2
   } state_e;

   // Galois MISR step: shift right, apply feedback on the bit shifted out, fold in the response.
   function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] cur,
                                                  input logic [N_OUT-1:0] r);
      logic [SIG_W-1:0] fb;
      fb = cur[0] ? POLY : {SIG_W{1'b0}};
      return (cur >> 1) ^ fb ^ SIG_W'(r);
   endfunction

   state_e            state_q, state_d;
   logic [N_IN-1:0]   pat_q, pat_d;
   logic [SIG_W-1:0]  misr_q, misr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              pass_q, pass_d;
   logic              err_q, err_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [SIG_W-1:0]  misr_acc;

   // Next-state and datapath for the sweep controller.
   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      misr_d   = misr_q;
      wait_d   = wait_q;
      pass_d   = pass_q;
      err_d    = err_q;
      misr_acc = misr_step(misr_q, resp);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               pat_d   = {N_IN{1'b0}};
               misr_d  = SEED;
               wait_d  = {WAIT_W{1'b0}};
               pass_d  = 1'b0;
               err_d   = 1'b0;
               state_d = ST_DRIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (resp_valid) begin
               misr_d = misr_acc;
               wait_d = {WAIT_W{1'b0}};
               // Grade on the final accept so pass is already valid while done is high.
               if (pat_q == PAT_LAST) begin
                  pass_d  = (misr_acc == GOLDEN) & ~err_q;
                  state_d = ST_FIN;
               end else begin
                  pat_d = pat_q + N_IN'(1);
               end
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               pass_d  = 1'b0;
               state_d = ST_FIN;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      valid_d = (state_d == ST_DRIVE);
      done_d  = (state_d == ST_FIN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pat_q   <= {N_IN{1'b0}};
         misr_q  <= SEED;
         wait_q  <= {WAIT_W{1'b0}};
         pass_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         misr_q  <= misr_d;
         wait_q  <= wait_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign pat       = pat_q;
   assign pat_valid = valid_q;
   assign busy      = valid_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err       = err_q;
   assign signature = misr_q;

endmodule

// File: tb/tb_ccg_resp_compactor.sv
// Directed bench: a 2-input instance checked against a reference MISR scoreboard,
// plus a 1-input instance with a constant response.
module tb_ccg_resp_compactor;

   logic        clk = 1'b0;
   logic        rst;
   logic        start2, rv2, start1;
   logic [11:0] resp2;
   logic [1:0]  pat2;
   logic        pv2, busy2, done2, pass2, err2;
   logic [15:0] sig2;
   logic [0:0]  pat1;
   logic        pv1, busy1, done1, pass1, err1;
   logic [15:0] sig1;

   int errors = 0;
   int checks = 0;

   logic        md, mfin, mpass, merr;
   logic [1:0]  mpat;
   logic [15:0] msig;
   int          mwait;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   ccg_resp_compactor #(.N_IN(2), .N_OUT(12), .SIG_W(16), .POLY(16'hB400), .SEED(16'h0001),
                        .GOLDEN(16'h1680), .TIMEOUT(4)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .pat(pat2), .pat_valid(pv2), .resp(resp2),
      .resp_valid(rv2), .busy(busy2), .done(done2), .pass(pass2), .err(err2), .signature(sig2));

   ccg_resp_compactor #(.N_IN(1), .N_OUT(12), .SIG_W(16), .POLY(16'hB400), .SEED(16'h0000),
                        .GOLDEN(16'h0000), .TIMEOUT(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .pat(pat1), .pat_valid(pv1), .resp(12'hFFF),
      .resp_valid(1'b1), .busy(busy1), .done(done1), .pass(pass1), .err(err1), .signature(sig1));

   function automatic logic [15:0] ref_misr(input logic [15:0] c, input logic [11:0] r);
      logic [15:0] s;
      s = {1'b0, c[15:1]};
      if (c[0]) s = s ^ 16'hB400;
      return s ^ {4'h0, r};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      md = 1'b0; mfin = 1'b0; mpass = 1'b0; merr = 1'b0;
      mpat = 2'd0; msig = 16'h0001; mwait = 0;
      exp_q.delete();
   endtask

   // One clock of dut2: drive, check against the model at negedge, advance the model,
   // then compare the signature produced by any accept after the edge.
   task automatic step(input logic st, input logic rv, input logic [11:0] rs);
      logic        pushed;
      logic [15:0] nx;
      start2 = st; rv2 = rv; resp2 = rs; pushed = 1'b0;
      @(negedge clk);
      chk1("pat_valid", pv2, md);
      chk1("busy", busy2, md);
      chk1("done", done2, mfin);
      chk1("pass", pass2, mpass);
      chk1("err", err2, merr);
      if (md) chk("pat", {14'd0, pat2}, {14'd0, mpat});
      if (mfin) chk("sig_at_done", sig2, msig);
      if (md) begin
         if (rv) begin
            nx = ref_misr(msig, rs);
            exp_q.push_back(nx);
            pushed = 1'b1;
            msig = nx;
            mwait = 0;
            if (mpat == 2'b11) begin
               md = 1'b0; mfin = 1'b1; mpass = (msig == 16'h1680);
            end else begin
               mpat = mpat + 2'd1;
            end
         end else if (mwait == 3) begin
            md = 1'b0; mfin = 1'b1; merr = 1'b1; mpass = 1'b0;
         end else begin
            mwait++;
         end
      end else if (mfin) begin
         mfin = 1'b0;
      end else if (st) begin
         md = 1'b1; mpat = 2'd0; msig = 16'h0001; mwait = 0; mpass = 1'b0; merr = 1'b0;
      end
      @(posedge clk); #1;
      if (pushed) chk("sig_after_accept", sig2, exp_q.pop_front());
   endtask

   initial begin
      rst = 1'b1; start2 = 1'b0; rv2 = 1'b0; resp2 = 12'h000; start1 = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_pat", {14'd0, pat2}, 16'h0000);
      chk1("rst_pat_valid", pv2, 1'b0);
      chk1("rst_busy", busy2, 1'b0);
      chk1("rst_done", done2, 1'b0);
      chk1("rst_pass", pass2, 1'b0);
      chk1("rst_err", err2, 1'b0);
      chk("rst_sig", sig2, 16'h0001);
      chk("rst_sig1", sig1, 16'h0000);

      // Zero-wait sweep with zero response: 1680 expected, done five cycles after start.
      step(1'b1, 1'b1, 12'h000);
      repeat (4) step(1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      chk("sweep_sig", sig2, 16'h1680);
      chk1("sweep_pass", pass2, 1'b1);
      chk1("sweep_err", err2, 1'b0);

      // One-input instance with constant FFF response.
      start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      chk1("n1_busy", busy1, 1'b1);
      chk("n1_pat0", {15'd0, pat1}, 16'h0000);
      @(posedge clk); #1;
      chk("n1_sig0", sig1, 16'h0FFF);
      chk("n1_pat1", {15'd0, pat1}, 16'h0001);
      @(posedge clk); #1;
      chk("n1_sig1", sig1, 16'hBC00);
      chk1("n1_done", done1, 1'b1);
      chk1("n1_pass", pass1, 1'b0);
      chk1("n1_err", err1, 1'b0);
      @(posedge clk); #1;
      chk1("n1_done_pulse", done1, 1'b0);

      // Three stall cycles before each accept.
      step(1'b1, 1'b0, 12'h000);
      for (int p = 0; p < 4; p++) begin
         repeat (3) step(1'b0, 1'b0, 12'h000);
         step(1'b0, 1'b1, 12'h000);
      end
      step(1'b0, 1'b0, 12'h000);
      chk("stall_sig", sig2, 16'h1680);
      chk1("stall_pass", pass2, 1'b1);

      // No response at all: timeout after four waiting cycles.
      step(1'b1, 1'b0, 12'h000);
      repeat (4) step(1'b0, 1'b0, 12'h000);
      step(1'b0, 1'b0, 12'h000);
      chk1("to_err", err2, 1'b1);
      chk1("to_pass", pass2, 1'b0);
      chk("to_sig", sig2, 16'h0001);

      // Random responses through the scoreboard.
      step(1'b1, 1'b1, 12'h000);
      repeat (4) step(1'b0, 1'b1, 12'($urandom_range(0, 4095)));
      step(1'b0, 1'b0, 12'h000);

      // Reset at pattern index 2.
      step(1'b1, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      chk("mid_pat", {14'd0, pat2}, 16'h0002);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      model_reset();
      chk("mrst_pat", {14'd0, pat2}, 16'h0000);
      chk1("mrst_pat_valid", pv2, 1'b0);
      chk1("mrst_done", done2, 1'b0);
      chk("mrst_sig", sig2, 16'h0001);
      repeat (3) step(1'b0, 1'b0, 12'h000);
      step(1'b1, 1'b1, 12'h000);
      repeat (5) step(1'b0, 1'b1, 12'h000);
      chk("rerun_sig", sig2, 16'h1680);

      // start pulsed during DRIVE and during FIN is ignored.
      step(1'b1, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      step(1'b1, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      step(1'b0, 1'b1, 12'h000);
      step(1'b1, 1'b0, 12'h000);
      repeat (2) step(1'b0, 1'b0, 12'h000);
      chk("ign_sig", sig2, 16'h1680);
      chk1("ign_pass", pass2, 1'b1);
      chk1("ign_idle", pv2, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
